// File: rtl/dense_output_layer.sv
// dense_output_layer
//
// Fully connected output layer. It computes NUM_OUT neuron sums over NUM_IN
// signed inputs, running one multiply-accumulate step per cycle for all
// neurons in parallel.
//
// Parameters
//   NUM_IN  : inputs per neuron (>= 2)
//   NUM_OUT : neuron count (>= 2)
//   IN_W    : signed input width
//   W_W     : signed weight width
//   ACC_W   : derived accumulator width, IN_W + W_W + clog2(NUM_IN)
//
// Ports
//   clk        : single clock, rising edge
//   rst        : asynchronous, active-high reset
//   in_valid   : input vector offered
//   in_ready   : layer can accept a vector (IDLE only)
//   in_data    : NUM_IN signed inputs, element k at [k*IN_W +: IN_W]
//   w_we       : weight write strobe (honoured in IDLE only)
//   w_addr     : weight index j*NUM_IN + k
//   w_data     : signed weight
//   out_valid  : results available (DONE)
//   out_ready  : consumer accepts results
//   out_data   : NUM_OUT signed sums, neuron j at [j*ACC_W +: ACC_W]
//   out_class  : argmax index of out_data
//
// Build option
//   DENSE_OUT_ARGMAX_EN : when defined, out_class is the index of the largest
//                         sum, and the lowest index wins ties. The value is
//                         registered on DONE entry. When undefined, out_class
//                         is tied to 0.
//
// FSM states
//   state | meaning
//   IDLE  | waiting for a vector; weights writable
//   ACCUM | one MAC per cycle for input index k, weights frozen
//   DONE  | results held until out_valid && out_ready

module dense_output_layer #(
    parameter int NUM_IN  = 4,
    parameter int NUM_OUT = 2,
    parameter int IN_W    = 12,
    parameter int W_W     = 5,
    localparam int ACC_W  = IN_W + W_W + $clog2(NUM_IN),
    localparam int WA     = $clog2(NUM_IN * NUM_OUT),
    localparam int CW     = ($clog2(NUM_OUT) > 1) ? $clog2(NUM_OUT) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NUM_IN*IN_W-1:0]     in_data,
    input  logic                       w_we,
    input  logic [WA-1:0]              w_addr,
    input  logic [W_W-1:0]             w_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NUM_OUT*ACC_W-1:0]   out_data,
    output logic [CW-1:0]              out_class
);

    localparam int KW = $clog2(NUM_IN);
    localparam int PW = IN_W + W_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [KW-1:0]           k;
    logic signed [IN_W-1:0]  x_reg   [NUM_IN];
    logic signed [W_W-1:0]   w_mem   [NUM_IN*NUM_OUT];
    logic signed [ACC_W-1:0] acc     [NUM_OUT];
    logic signed [ACC_W-1:0] acc_nxt [NUM_OUT];
    logic signed [IN_W-1:0]  x_cur;
    logic                    accept;
    logic                    last_mac;
    logic                    w_wr_en;

    assign accept    = (state == IDLE) && in_valid;
    assign last_mac  = (state == ACCUM) && (k == KW'(NUM_IN - 1));
    assign w_wr_en   = (state == IDLE) && w_we && (int'(w_addr) < NUM_IN * NUM_OUT);
    // in_ready is gated by rst so that it reads 0 throughout reset.
    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign x_cur     = x_reg[k];

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = ACCUM;
            ACCUM:   if (last_mac)  state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Weight store
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_IN * NUM_OUT; i++) begin
                w_mem[i] <= '0;
            end
        end else if (w_wr_en) begin
            w_mem[w_addr] <= w_data;
        end
    end

    // ------------------------------------------------------------------
    // MAC lanes: full-precision product, sign-extended into the accumulator
    // ------------------------------------------------------------------
    for (genvar j = 0; j < NUM_OUT; j++) begin : g_mac
        logic [WA-1:0]          w_idx;
        logic signed [PW-1:0]   prod;

        assign w_idx      = WA'(j * NUM_IN) + WA'(k);
        assign prod       = PW'(x_cur) * PW'(w_mem[w_idx]);
        assign acc_nxt[j] = acc[j] + {{(ACC_W - PW){prod[PW-1]}}, prod};
        // The accumulators are the result registers. They keep the last
        // result until the next accept edge clears them.
        assign out_data[j*ACC_W +: ACC_W] = acc[j];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k <= '0;
            for (int i = 0; i < NUM_IN; i++) begin
                x_reg[i] <= '0;
            end
            for (int j = 0; j < NUM_OUT; j++) begin
                acc[j] <= '0;
            end
        end else if (accept) begin
            k <= '0;
            for (int i = 0; i < NUM_IN; i++) begin
                x_reg[i] <= in_data[i*IN_W +: IN_W];
            end
            for (int j = 0; j < NUM_OUT; j++) begin
                acc[j] <= '0;
            end
        end else if (state == ACCUM) begin
            k <= last_mac ? '0 : k + KW'(1);
            for (int j = 0; j < NUM_OUT; j++) begin
                acc[j] <= acc_nxt[j];
            end
        end
    end

    // ------------------------------------------------------------------
    // Argmax
    // ------------------------------------------------------------------
`ifdef DENSE_OUT_ARGMAX_EN
    logic [CW-1:0]           best_idx;
    logic signed [ACC_W-1:0] best_val;
    logic [CW-1:0]           class_reg;

    // The search runs on the sums being written at the final MAC edge, so
    // out_class becomes valid on the same edge as out_valid. Strict '>'
    // keeps the lowest index on ties.
    always_comb begin
        best_idx = '0;
        best_val = acc_nxt[0];
        for (int j = 1; j < NUM_OUT; j++) begin
            if (acc_nxt[j] > best_val) begin
                best_val = acc_nxt[j];
                best_idx = CW'(j);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            class_reg <= '0;
        end else if (last_mac) begin
            class_reg <= best_idx;
        end
    end

    assign out_class = class_reg;
`else
    assign out_class = '0;
`endif

endmodule
